// File: rtl/gate_exerciser.sv
// Stimulus/response checker for a 2-input gate: sweeps {a,b} through 00..11, samples y after a
// settle interval and compares it against the TRUTH table, reporting a verdict and error count.
`timescale 1ns/1ps
module gate_exerciser #(
   parameter logic [3:0]  TRUTH  = 4'b0111,
   parameter int unsigned SETTLE = 1,
   parameter int unsigned PASSES = 1,
   parameter int unsigned ERRW   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            a,
   output logic            b,
   input  logic            y,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [ERRW-1:0] err_count,
   output logic            fail_valid,
   output logic [1:0]      fail_vec
);

   typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

   localparam logic [7:0]      CntLoad  = 8'(SETTLE - 1);
   localparam logic [7:0]      LastPass = 8'(PASSES - 1);
   localparam logic [ERRW-1:0] ErrMax   = '1;

   state_e          state_q, state_d;
   logic [1:0]      vec_q, vec_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      pass_idx_q, pass_idx_d;
   logic [1:0]      ab_q, ab_d;
   logic            pass_q, pass_d;
   logic [ERRW-1:0] err_q, err_d;
   logic            fv_q, fv_d;
   logic [1:0]      fvec_q, fvec_d;
   logic            mismatch;

   assign mismatch = (y != TRUTH[vec_q]);

   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      cnt_d      = cnt_q;
      pass_idx_d = pass_idx_q;
      pass_d     = pass_q;
      err_d      = err_q;
      fv_d       = fv_q;
      fvec_d     = fvec_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StDrive;
               vec_d      = 2'd0;
               pass_idx_d = 8'd0;
               cnt_d      = CntLoad;
               pass_d     = 1'b0;
               err_d      = '0;
               fv_d       = 1'b0;
               fvec_d     = 2'd0;
            end
         end
         StDrive: begin
            if (cnt_q == 8'd0) begin
               state_d = StSample;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StSample: begin
            if (mismatch) begin
               if (err_q != ErrMax) begin
                  err_d = err_q + 1'b1;
               end
               if (!fv_q) begin
                  fv_d   = 1'b1;
                  fvec_d = vec_q;
               end
            end
            cnt_d   = CntLoad;
            state_d = StDrive;
            if (vec_q != 2'd3) begin
               vec_d = vec_q + 2'd1;
            end else if (pass_idx_q != LastPass) begin
               vec_d      = 2'd0;
               pass_idx_d = pass_idx_q + 8'd1;
            end else begin
               // Verdict includes this final comparison, so it is visible alongside done.
               state_d = StDone;
               pass_d  = (err_d == '0);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      ab_d = ((state_d == StDrive) || (state_d == StSample)) ? vec_d : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         vec_q      <= 2'd0;
         cnt_q      <= 8'd0;
         pass_idx_q <= 8'd0;
         ab_q       <= 2'b00;
         pass_q     <= 1'b0;
         err_q      <= '0;
         fv_q       <= 1'b0;
         fvec_q     <= 2'd0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         pass_idx_q <= pass_idx_d;
         ab_q       <= ab_d;
         pass_q     <= pass_d;
         err_q      <= err_d;
         fv_q       <= fv_d;
         fvec_q     <= fvec_d;
      end
   end

   assign a          = ab_q[1];
   assign b          = ab_q[0];
   assign busy       = (state_q == StDrive) || (state_q == StSample);
   assign done       = (state_q == StDone);
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus/response stage for 2-input logic gates. It sits directly upstream and downstream of a gate under test such as the NAND cell: it drives the gate's `a`/`b` inputs through the full truth table, samples the gate's `y` output after a settle interval, and compares it against a parameterised expected truth table. It reports a pass/fail verdict, an error count and the first failing vector, so gate checks run as synthesizable, cycle-accurate hardware rather than ad-hoc `$display` sweeps.

## Interface
Parameters:
- `TRUTH`, default 4'b0111: expected `y`, indexed by `{a,b}`; bit0 is the 00 case. The default is NAND.
- `SETTLE`, default 1: drive cycles per vector before the sample cycle; legal range 1..255.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- `ERRW`, default 8: width of the error counter.

Ports:
- `clk` input 1: sole clock; everything updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `start` input 1: run request; sampled only in IDLE.
- `a` output 1: stimulus to the gate's first input.
- `b` output 1: stimulus to the gate's second input.
- `y` input 1: response from the gate under test.
- `busy` output 1: high while a run is in progress.
- `done` output 1: single-cycle pulse at run end.
- `pass` output 1: verdict of the last completed run, held until the next start.
- `err_count` output ERRW: mismatch count of the current or last run, saturating.
- `fail_valid` output 1: at least one mismatch has been captured.
- `fail_vec` output 2: `{a,b}` of the first mismatch in the run.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - `a=b=0`, `busy=0`.
  - On `start=1`: clear `err_count`, `fail_valid`, `fail_vec` and `pass`; set `vec=0`, `pass_idx=0`, `cnt=SETTLE-1`; go to DRIVE.
- DRIVE:
  - `{a,b}=vec`, `busy=1`.
  - If `cnt==0`, go to SAMPLE; otherwise decrement `cnt`.
- SAMPLE:
  - `{a,b}=vec` is still driven.
  - At the edge that ends this cycle, compare `y` against `TRUTH[vec]`.
  - On mismatch: `err_count` increments, saturating at all-ones. If `fail_valid==0`, set `fail_valid=1` and `fail_vec=vec`.
  - If `vec!=3`: `vec++`, reload `cnt`, go to DRIVE.
  - If `vec==3` and `pass_idx!=PASSES-1`: `vec=0`, `pass_idx++`, reload `cnt`, go to DRIVE.
  - Otherwise go to DONE.
- DONE:
  - `done=1` for exactly one cycle, `busy=0`, `a=b=0`.
  - `pass` is loaded with the result including the final SAMPLE comparison (`err_count==0` after that update).
  - Go to IDLE.
- Vector order is fixed: 00, 01, 10, 11, repeated PASSES times.
- `start` while busy or in DONE: ignored, no effect.
- `pass`, `err_count`, `fail_valid` and `fail_vec` hold their values in IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, `a=0`, `b=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `fail_valid=0`, `fail_vec=2'b00`.
- `rst` asserted in any state, including mid-run, returns to these values on the next edge. A partial run produces no `done`.
- Latency:
  - Start accepted at edge T, so `busy=1` and the first vector appear from T+1.
  - Each vector is held for SETTLE+1 cycles.
  - `busy` stays high for 4·PASSES·(SETTLE+1) cycles.
  - `done` goes high in the cycle immediately after the last SAMPLE.
- Comparison point: the gate under test must produce `y` within SETTLE+1 cycles of a vector change, which covers combinational or registered gates up to SETTLE cycles deep.
- Vector transitions are glitch-free at the outputs: `a` and `b` are registered.
- Saturation: once `err_count` reaches 2^ERRW−1 it holds there. `pass` stays 0.

## Test plan
- NAND model wired, defaults (`TRUTH=0111`, `SETTLE=1`, `PASSES=1`), `start` pulsed → `busy` high for 8 cycles, `{a,b}` = 00,01,10,11 with each held 2 cycles, `done` pulses once, `pass=1`, `err_count=0`, `fail_valid=0`.
- `y` tied to 1, defaults → `err_count=1`, `fail_valid=1`, `fail_vec=11`, `pass=0`.
- AND gate wired instead of NAND, defaults → `err_count=4`, `fail_vec=00`, `pass=0`.
- `y` tied to 0, `PASSES=3`, `SETTLE=2` → `busy` high for 36 cycles, `err_count=9`, `fail_vec=00`. Same stimulus with `ERRW=2` → `err_count` saturates at 3.
- `start` re-pulsed mid-run → ignored, run completes normally with a single `done`. Then `rst` asserted at cycle 3 of a new run → next cycle all outputs are at reset values, no `done`, and a subsequent start completes cleanly.
- Registered NAND (1-cycle delay) with `SETTLE=1` → `pass=1`. Registered NAND with 2-cycle delay and `SETTLE=1` → `pass=0`, `err_count>0`.
